// File: rtl/lcd_win_ctrl.sv
// lcd_win_ctrl: loads an IMG_W x IMG_H image from IROM, runs window commands on a WIN x WIN
// window, and streams the buffer to IRAM on WRITE.
module lcd_win_ctrl #(
   parameter int unsigned DW    = 8,
   parameter int unsigned IMG_W = 8,
   parameter int unsigned IMG_H = 8,
   parameter int unsigned WIN   = 4,
   parameter int unsigned AW    = $clog2(IMG_W * IMG_H)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [3:0]    cmd,
   input  logic          cmd_valid,
   input  logic [DW-1:0] IROM_Q,
   output logic          IROM_rd,
   output logic [AW-1:0] IROM_A,
   output logic          IRAM_ceb,
   output logic          IRAM_web,
   output logic [AW-1:0] IRAM_A,
   output logic [DW-1:0] IRAM_D,
   output logic          busy,
   output logic          done
);
   localparam int unsigned N  = IMG_W * IMG_H;
   localparam int unsigned XW = $clog2(IMG_W);
   localparam int unsigned YW = $clog2(IMG_H);
   localparam int unsigned LW = $clog2(WIN);
   localparam int unsigned IW = 2 * LW;
   localparam int unsigned SW = DW + IW;
   localparam int unsigned CW = AW + 1;

   localparam logic [XW-1:0] OX0      = XW'((IMG_W - WIN) / 2);
   localparam logic [YW-1:0] OY0      = YW'((IMG_H - WIN) / 2);
   localparam logic [XW-1:0] OX_MAX   = XW'(IMG_W - WIN);
   localparam logic [YW-1:0] OY_MAX   = YW'(IMG_H - WIN);
   localparam logic [IW-1:0] IDX_LAST = IW'(WIN * WIN - 1);

   localparam logic [3:0] CMD_WRITE  = 4'd0;
   localparam logic [3:0] CMD_UP     = 4'd1;
   localparam logic [3:0] CMD_DOWN   = 4'd2;
   localparam logic [3:0] CMD_LEFT   = 4'd3;
   localparam logic [3:0] CMD_RIGHT  = 4'd4;
   localparam logic [3:0] CMD_MAX    = 4'd5;
   localparam logic [3:0] CMD_MIN    = 4'd6;
   localparam logic [3:0] CMD_AVG    = 4'd7;
   localparam logic [3:0] CMD_CENTER = 4'd8;
   localparam logic [3:0] CMD_INVERT = 4'd9;

   typedef enum logic [2:0] {
      S_LOAD, S_IDLE, S_MOVE, S_SCAN, S_APPLY, S_WRITE, S_DONE
   } state_e;

   state_e          state_q;
   logic [CW-1:0]   cnt_q;
   logic [IW-1:0]   idx_q;
   logic [XW-1:0]   ox_q, wx_q;
   logic [YW-1:0]   oy_q, wy_q;
   logic [3:0]      cmd_q;
   logic [DW-1:0]   max_q, min_q;
   logic [SW-1:0]   sum_q;
   logic            cap_en_q;
   logic [AW-1:0]   cap_addr_q;
   logic [DW-1:0]   pix_q [N];

   logic [XW-1:0]   win_x_c;
   logic [YW-1:0]   win_y_c;
   logic [AW-1:0]   win_addr_c;
   logic [DW-1:0]   pix_rd_c;
   logic [DW-1:0]   apply_c;
   logic            we_c;
   logic [AW-1:0]   waddr_c;
   logic [DW-1:0]   wdata_c;

   // Window walk: idx low bits are the column, high bits the row.
   assign win_x_c    = wx_q + XW'(idx_q[LW-1:0]);
   assign win_y_c    = wy_q + YW'(idx_q[IW-1:LW]);
   assign win_addr_c = {win_y_c, win_x_c};
   assign pix_rd_c   = pix_q[win_addr_c];

   always_comb begin
      apply_c = ~pix_rd_c;
      case (cmd_q)
         CMD_MAX: apply_c = max_q;
         CMD_MIN: apply_c = min_q;
         CMD_AVG: apply_c = sum_q[SW-1 -: DW];
         default: apply_c = ~pix_rd_c;
      endcase
   end

   // Single buffer write port shared by ROM capture and APPLY.
   always_comb begin
      we_c    = 1'b0;
      waddr_c = cap_addr_q;
      wdata_c = IROM_Q;
      if (state_q == S_APPLY) begin
         we_c    = 1'b1;
         waddr_c = win_addr_c;
         wdata_c = apply_c;
      end else if (cap_en_q) begin
         we_c = 1'b1;
      end
      if (rst) we_c = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (we_c) pix_q[waddr_c] <= wdata_c;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_LOAD;
         cnt_q      <= '0;
         idx_q      <= '0;
         ox_q       <= OX0;
         oy_q       <= OY0;
         wx_q       <= OX0;
         wy_q       <= OY0;
         cmd_q      <= '0;
         max_q      <= '0;
         min_q      <= '0;
         sum_q      <= '0;
         cap_en_q   <= 1'b0;
         cap_addr_q <= '0;
         IROM_rd    <= 1'b0;
         IROM_A     <= '0;
         IRAM_ceb   <= 1'b0;
         IRAM_web   <= 1'b1;
         IRAM_A     <= '0;
         IRAM_D     <= '0;
         busy       <= 1'b1;
         done       <= 1'b0;
      end else begin
         // ROM data trails the address by one cycle.
         cap_en_q   <= IROM_rd;
         cap_addr_q <= IROM_A;
         case (state_q)
            S_LOAD: begin
               if (cnt_q < CW'(N)) begin
                  IROM_rd <= 1'b1;
                  IROM_A  <= cnt_q[AW-1:0];
               end else begin
                  IROM_rd <= 1'b0;
               end
               if (cnt_q == CW'(N + 1)) begin
                  state_q <= S_IDLE;
                  busy    <= 1'b0;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_IDLE: begin
               if (cmd_valid) begin
                  busy  <= 1'b1;
                  cmd_q <= cmd;
                  wx_q  <= ox_q;
                  wy_q  <= oy_q;
                  idx_q <= '0;
                  case (cmd)
                     CMD_WRITE: begin
                        state_q  <= S_WRITE;
                        IRAM_ceb <= 1'b1;
                        IRAM_web <= 1'b0;
                        IRAM_A   <= '0;
                        IRAM_D   <= pix_q[0];
                        cnt_q    <= CW'(1);
                     end
                     CMD_MAX, CMD_MIN, CMD_AVG: state_q <= S_SCAN;
                     CMD_INVERT:                state_q <= S_APPLY;
                     default:                   state_q <= S_MOVE;
                  endcase
               end
            end
            S_MOVE: begin
               case (cmd_q)
                  CMD_UP:     if (oy_q != '0)     oy_q <= oy_q - YW'(1);
                  CMD_DOWN:   if (oy_q != OY_MAX) oy_q <= oy_q + YW'(1);
                  CMD_LEFT:   if (ox_q != '0)     ox_q <= ox_q - XW'(1);
                  CMD_RIGHT:  if (ox_q != OX_MAX) ox_q <= ox_q + XW'(1);
                  CMD_CENTER: begin
                     ox_q <= OX0;
                     oy_q <= OY0;
                  end
                  default: ;
               endcase
               state_q <= S_IDLE;
               busy    <= 1'b0;
            end
            S_SCAN: begin
               if (idx_q == '0) begin
                  max_q <= pix_rd_c;
                  min_q <= pix_rd_c;
                  sum_q <= SW'(pix_rd_c);
               end else begin
                  if (pix_rd_c > max_q) max_q <= pix_rd_c;
                  if (pix_rd_c < min_q) min_q <= pix_rd_c;
                  sum_q <= sum_q + SW'(pix_rd_c);
               end
               idx_q <= idx_q + IW'(1);
               if (idx_q == IDX_LAST) state_q <= S_APPLY;
            end
            S_APPLY: begin
               idx_q <= idx_q + IW'(1);
               if (idx_q == IDX_LAST) begin
                  state_q <= S_IDLE;
                  busy    <= 1'b0;
               end
            end
            S_WRITE: begin
               if (cnt_q == CW'(N)) begin
                  IRAM_ceb <= 1'b0;
                  IRAM_web <= 1'b1;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state_q  <= S_DONE;
               end else begin
                  IRAM_A <= cnt_q[AW-1:0];
                  IRAM_D <= pix_q[cnt_q[AW-1:0]];
                  cnt_q  <= cnt_q + CW'(1);
               end
            end
            S_DONE: ;
            default: state_q <= S_LOAD;
         endcase
      end
   end
endmodule

// File: tb/tb_lcd_win_ctrl.sv
// Directed bench for lcd_win_ctrl: default 8x8/WIN=4 instance plus a 16x8/WIN=2 instance.
`timescale 1ns/1ps
module tb_lcd_win_ctrl;
   localparam logic [3:0] CMD_WRITE = 4'd0;
   localparam logic [3:0] CMD_MAX   = 4'd5;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] cmd;
   logic       cmd_valid;

   logic [7:0] rom_q;
   logic       IROM_rd, IRAM_ceb, IRAM_web, busy, done;
   logic [5:0] IROM_A, IRAM_A;
   logic [7:0] IRAM_D;

   logic [7:0] rom2_q;
   logic       irom_rd2, iram_ceb2, iram_web2, busy2, done2;
   logic [6:0] irom_a2, iram_a2;
   logic [7:0] iram_d2;

   logic [7:0] cap1 [64];
   logic [7:0] cap2 [128];

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   lcd_win_ctrl dut (
      .clk(clk), .rst(rst), .cmd(cmd), .cmd_valid(cmd_valid),
      .IROM_Q(rom_q), .IROM_rd(IROM_rd), .IROM_A(IROM_A),
      .IRAM_ceb(IRAM_ceb), .IRAM_web(IRAM_web), .IRAM_A(IRAM_A), .IRAM_D(IRAM_D),
      .busy(busy), .done(done)
   );

   lcd_win_ctrl #(.DW(8), .IMG_W(16), .IMG_H(8), .WIN(2)) dut2 (
      .clk(clk), .rst(rst), .cmd(cmd), .cmd_valid(cmd_valid),
      .IROM_Q(rom2_q), .IROM_rd(irom_rd2), .IROM_A(irom_a2),
      .IRAM_ceb(iram_ceb2), .IRAM_web(iram_web2), .IRAM_A(iram_a2), .IRAM_D(iram_d2),
      .busy(busy2), .done(done2)
   );

   // Synchronous ROMs holding ROM[k] = k % 256.
   always @(posedge clk) if (IROM_rd)  rom_q  <= 8'(IROM_A);
   always @(posedge clk) if (irom_rd2) rom2_q <= 8'(irom_a2);

   typedef struct {
      string            name;
      int               ncmd;
      logic [11:0][3:0] cmds;      // cmds[0] issued first
      int               busy_last;
      int               x0;
      int               y0;
      int               kind;      // 0 unchanged, 1 window filled with val, 2 window inverted
      int               val;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input string nm, input int n, input logic [47:0] c,
                               input int b, input int x0, input int y0,
                               input int kind, input int val);
      vec_t v;
      v.name = nm; v.ncmd = n; v.cmds = c; v.busy_last = b;
      v.x0 = x0; v.y0 = y0; v.kind = kind; v.val = val;
      return v;
   endfunction

   function automatic logic [7:0] exp_pix(input vec_t v, input int k);
      int x = k % 8;
      int y = k / 8;
      bit inwin = (x >= v.x0) && (x < v.x0 + 4) && (y >= v.y0) && (y < v.y0 + 4);
      if (inwin && v.kind == 1) return 8'(v.val);
      if (inwin && v.kind == 2) return 8'(255 - k);
      return 8'(k);
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   task automatic reset_load(input bit hold);
      int bad  = 0;
      int fall = 0;
      rst = 1'b1;
      cmd_valid = hold;
      cmd = hold ? CMD_MAX : 4'd0;
      repeat (2) @(negedge clk);
      check("rst_vals",
            32'({IROM_rd, IROM_A, IRAM_ceb, IRAM_web, IRAM_A, IRAM_D, busy, done}),
            32'({1'b0, 6'd0, 1'b0, 1'b1, 6'd0, 8'd0, 1'b1, 1'b0}));
      rst = 1'b0;
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         if (c <= 64) begin
            if (IROM_rd !== 1'b1 || IROM_A !== 6'(c - 1)) bad++;
         end else if (IROM_rd !== 1'b0) begin
            bad++;
         end
         if (busy === 1'b0) begin
            fall = c;
            break;
         end
      end
      check("load_seq", bad, 0);
      check("load_busy_fall", fall, 66);
   endtask

   task automatic run_cmd(input logic [3:0] c, output int bc);
      cmd = c;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      bc = 0;
      while (busy === 1'b1 && bc < 1000) begin
         bc++;
         @(negedge clk);
      end
   endtask

   task automatic write_capture();
      int bad = 0;
      cmd = CMD_WRITE;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int k = 0; k < 64; k++) begin
         if (IRAM_ceb !== 1'b1 || IRAM_web !== 1'b0 || IRAM_A !== 6'(k) ||
             busy !== 1'b1 || done !== 1'b0) bad++;
         cap1[k] = IRAM_D;
         @(negedge clk);
      end
      check("wr_stream", bad, 0);
      check("wr_end", 32'({IRAM_ceb, IRAM_web, busy, done}), 32'(4'b0101));
      cmd = CMD_MAX;
      cmd_valid = 1'b1;
      repeat (3) @(negedge clk);
      cmd_valid = 1'b0;
      check("done_hold", 32'({IRAM_ceb, IRAM_web, busy, done}), 32'(4'b0101));
   endtask

   task automatic compare_image(input vec_t v);
      int nbad  = 0;
      int first = -1;
      for (int k = 0; k < 64; k++) begin
         if (cap1[k] !== exp_pix(v, k)) begin
            nbad++;
            if (first < 0) first = k;
         end
      end
      check($sformatf("img_%s (first bad px %0d)", v.name, first), nbad, 0);
   endtask

   task automatic run_vec(input vec_t v);
      int bc = 0;
      reset_load(1'b0);
      for (int i = 0; i < v.ncmd; i++) run_cmd(v.cmds[i], bc);
      if (v.ncmd > 0) check({"busy_", v.name}, bc, v.busy_last);
      write_capture();
      compare_image(v);
   endtask

   // MAX held on cmd_valid through LOAD and into SCAN must be taken exactly once.
   task automatic hold_test();
      int bc = 0;
      int idle_bad = 0;
      reset_load(1'b1);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (i == 4) cmd_valid = 1'b0;
         if (busy !== 1'b1) break;
         bc++;
      end
      cmd_valid = 1'b0;
      check("hold_busy", bc, 32);
      for (int i = 0; i < 3; i++) begin
         if (busy !== 1'b0) idle_bad++;
         @(negedge clk);
      end
      check("hold_idle", idle_bad, 0);
      write_capture();
      compare_image(mk("hold_max", 1, 48'h5, 32, 2, 2, 1, 45));
   endtask

   task automatic apply_reset_test();
      int bc = 0;
      reset_load(1'b0);
      cmd = CMD_MAX;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (20) @(negedge clk);
      check("mid_apply_busy", busy, 1);
      reset_load(1'b0);
      write_capture();
      compare_image(mk("after_rst", 0, 48'h0, 0, 0, 0, 0, 0));
      run_cmd(4'd0, bc);
   endtask

   task automatic dut2_test();
      int fall = 0;
      int bc   = 0;
      int cnt  = 0;
      int bad  = 0;
      int nbad = 0;
      rst = 1'b1;
      cmd_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("p2_rst", 32'({irom_rd2, iram_ceb2, iram_web2, busy2, done2}), 32'(5'b00110));
      rst = 1'b0;
      for (int c = 1; c <= 400; c++) begin
         @(negedge clk);
         if (busy2 === 1'b0) begin
            fall = c;
            break;
         end
      end
      check("p2_load_fall", fall, 130);
      cmd = CMD_MAX;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      while (busy2 === 1'b1 && bc < 100) begin
         bc++;
         @(negedge clk);
      end
      check("p2_max_busy", bc, 8);
      cmd = CMD_WRITE;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      while (iram_ceb2 === 1'b1 && cnt < 300) begin
         if (iram_web2 !== 1'b0 || iram_a2 !== 7'(cnt)) bad++;
         cap2[7'(cnt)] = iram_d2;
         cnt++;
         @(negedge clk);
      end
      check("p2_wr_words", cnt, 128);
      check("p2_wr_seq", bad, 0);
      check("p2_done", done2, 1);
      for (int k = 0; k < 128; k++) begin
         logic [7:0] e;
         e = (k == 55 || k == 56 || k == 71 || k == 72) ? 8'd72 : 8'(k);
         if (cap2[k] !== e) nbad++;
      end
      check("p2_img", nbad, 0);
   endtask

   initial begin
      rst = 1'b1;
      cmd = '0;
      cmd_valid = 1'b0;
      vecs.push_back(mk("write_only",    0, 48'h0,             0, 0, 0, 0, 0));
      vecs.push_back(mk("max",           1, 48'h5,            32, 2, 2, 1, 45));
      vecs.push_back(mk("min",           1, 48'h6,            32, 2, 2, 1, 18));
      vecs.push_back(mk("avg",           1, 48'h7,            32, 2, 2, 1, 31));
      vecs.push_back(mk("up2_avg",       3, 48'h711,          32, 2, 0, 1, 15));
      vecs.push_back(mk("left5_max",     6, 48'h53_3333,      32, 0, 2, 1, 43));
      vecs.push_back(mk("right3_max",    4, 48'h5444,         32, 4, 2, 1, 47));
      vecs.push_back(mk("up3_down_max",  5, 48'h52111,        32, 2, 1, 1, 37));
      vecs.push_back(mk("down3_min",     4, 48'h6222,         32, 2, 4, 1, 34));
      vecs.push_back(mk("r8_center_max", 10, 48'h58_4444_4444, 32, 2, 2, 1, 45));
      vecs.push_back(mk("invert",        1, 48'h9,            16, 2, 2, 2, 0));
      vecs.push_back(mk("invert_twice",  2, 48'h99,           16, 0, 0, 0, 0));
      vecs.push_back(mk("left_invert",   2, 48'h93,           16, 1, 2, 2, 0));
      vecs.push_back(mk("code12",        1, 48'hC,             1, 0, 0, 0, 0));
      vecs.push_back(mk("center",        1, 48'h8,             1, 0, 0, 0, 0));
      repeat (2) @(negedge clk);
      foreach (vecs[i]) run_vec(vecs[i]);
      hold_test();
      apply_reset_test();
      dut2_test();
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_chk);
      $fatal(1);
   end
endmodule
